wb_pipe2std_bridge: RTL
=======================

// Module: wb_pipe2std_bridge
// PURPOSE
//  Wishbone B4 bridge: pipelined master port (upstream) to standard/classic slave port (downstream).
//  A parametrised request FIFO lets the master issue back-to-back strobes.
//  The FSM replays each request as a classic cycle and returns acks upstream in order.
//  Adds byte selects, err propagation, a watchdog timeout and cycle abort.
//  Sits between pipelined masters and legacy standard slaves in place of a fixed-width wrapper.
// PARAMETERS
//  ADR_WIDTH  16  address width, both ports
//  DAT_WIDTH  16  data width; must be a multiple of 8
//  DEPTH      4   request FIFO entries; power of 2, >=2
//  TIMEOUT    16  cycles without m_ack/m_err before a synthetic error; 0 disables the watchdog
// PORTS
//  clk      in   1              single clock, rising edge
//  rst      in   1              synchronous, active-high reset
//  s_cyc    in   1              upstream cycle
//  s_stb    in   1              upstream strobe (pipelined)
//  s_we     in   1              upstream write enable
//  s_adr    in   ADR_WIDTH      upstream address
//  s_dat_i  in   DAT_WIDTH      upstream write data
//  s_sel    in   DAT_WIDTH/8    upstream byte selects
//  s_stall  out  1              upstream stall
//  s_ack    out  1              upstream ack, registered
//  s_err    out  1              upstream error, registered
//  s_dat_o  out  DAT_WIDTH      upstream read data, registered
//  m_cyc    out  1              downstream cycle
//  m_stb    out  1              downstream strobe (classic)
//  m_we     out  1              downstream write enable
//  m_adr    out  ADR_WIDTH      downstream address
//  m_dat_o  out  DAT_WIDTH      downstream write data
//  m_sel    out  DAT_WIDTH/8    downstream byte selects
//  m_ack    in   1              downstream ack
//  m_err    in   1              downstream error
//  m_dat_i  in   DAT_WIDTH      downstream read data
// BEHAVIOUR
//  Reset values:
//   - s_ack, s_err, m_cyc, m_stb = 0; s_dat_o = 0.
//   - FIFO empty, watchdog = 0, FSM in IDLE.
//   - s_stall = 0 after reset.
//  Accept and stall:
//   - A request is accepted when s_cyc & s_stb & !s_stall.
//   - {we,adr,dat,sel} is pushed into the FIFO.
//   - s_stall = (count==DEPTH), driven from the registered count only; no push at full, even if a pop occurs the same cycle.
//  FSM:
//   - IDLE: m_cyc=m_stb=0. Goes to REQ when the FIFO is non-empty.
//   - REQ: m_cyc=m_stb=1. m_we/m_adr/m_dat_o/m_sel come from the FIFO head.
//   - In REQ, m_ack or m_err pops the head in the same cycle.
//   - After the pop, the FSM stays in REQ if more entries remain. The next head is presented the following cycle, so classic strobes run back-to-back.
//   - Otherwise the FSM returns to IDLE.
//  Latency:
//   - Accept at edge N with empty FIFO and IDLE: m_stb=1 at N+1.
//   - m_ack at cycle M: s_ack=1 at M+1, with s_dat_o = m_dat_i captured at M.
//   - s_dat_o is updated on reads only; it holds its value on writes.
//  Errors:
//   - m_err gives s_err=1 at M+1 (not s_ack). m_ack and m_err together: err wins.
//   - The watchdog counts REQ cycles without m_ack/m_err and clears on each pop.
//   - When it reaches TIMEOUT: pop, pulse s_err next cycle, deassert m_stb for one cycle, then continue with the next entry.
//  Ordering: exactly one s_ack or s_err per accepted request, in acceptance order; never two responses in one cycle.
//  Abort:
//   - s_cyc low while entries are queued or in flight: flush the FIFO and clear the watchdog.
//   - m_cyc=m_stb=0 on the next cycle; FSM to IDLE.
//   - Any m_ack in the abort cycle is ignored; no s_ack/s_err after the abort edge.
//  m_cyc is never high while m_stb is low, except the one-cycle gap after a timeout.
//  Reset mid-operation: all state returns to the reset values at the next edge; queued requests are discarded with no response.
// TESTING
//  1. 10 single writes adr 1..10, dat 101..110, one idle cycle between each
//     -> each s_ack 2 cycles after accept for a 0-wait slave; slave mem[i]=100+i.
//  2. 10 single reads adr 1..10 -> s_dat_o = 101..110 in order, one s_ack each, s_err never set.
//  3. Back-to-back pipelined writes adr 11..20, dat 211..220, DEPTH=4, 1-wait-state slave
//     -> s_stall asserts when 4 entries are queued; 10 acks; mem correct; m_stb never drops mid-burst.
//  4. Slave never acks adr 0x00FF, TIMEOUT=16 -> s_err exactly 17 cycles after m_stb rises; the next queued read completes normally.
//  5. Queue 3 reads, drop s_cyc while the 1st is stalled on the slave
//     -> m_cyc=0 next cycle, FIFO count=0, zero further s_ack/s_err.
//  6. Assert rst for 1 cycle during the 5th entry of the burst in test 3
//     -> all outputs at reset values the next cycle; a following write/read to adr 3 works.

Source files
------------

// File: rtl/wb_pipe2std_bridge.sv
// wb_pipe2std_bridge: Wishbone B4 pipelined master port to classic slave port bridge
module wb_pipe2std_bridge #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_cyc,
  input  logic                   s_stb,
  input  logic                   s_we,
  input  logic [ADR_WIDTH-1:0]   s_adr,
  input  logic [DAT_WIDTH-1:0]   s_dat_i,
  input  logic [DAT_WIDTH/8-1:0] s_sel,
  output logic                   s_stall,
  output logic                   s_ack,
  output logic                   s_err,
  output logic [DAT_WIDTH-1:0]   s_dat_o,
  output logic                   m_cyc,
  output logic                   m_stb,
  output logic                   m_we,
  output logic [ADR_WIDTH-1:0]   m_adr,
  output logic [DAT_WIDTH-1:0]   m_dat_o,
  output logic [DAT_WIDTH/8-1:0] m_sel,
  input  logic                   m_ack,
  input  logic                   m_err,
  input  logic [DAT_WIDTH-1:0]   m_dat_i
);
  localparam int SW = DAT_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + ADR_WIDTH + DAT_WIDTH + SW;
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t st_q, st_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic s_ack_q, s_err_q;
  logic [DAT_WIDTH-1:0] s_dat_q;
  logic abort, push, done, tmo, pop;
  assign abort   = !s_cyc;
  assign s_stall = cnt_q == (AW+1)'(DEPTH);
  assign push    = s_cyc & s_stb & !s_stall;
  assign done    = st_q == REQ & (m_ack | m_err) & !abort;
  assign tmo     = TIMEOUT != 0 && st_q == REQ && !m_ack && !m_err && !abort && wd_q == WW'(TIMEOUT);
  assign pop     = done | tmo;
  assign {m_we, m_adr, m_dat_o, m_sel} = mem_q[rd_q];
  assign m_stb   = st_q == REQ;
  assign m_cyc   = st_q != IDLE;
  assign s_ack   = s_ack_q;
  assign s_err   = s_err_q;
  assign s_dat_o = s_dat_q;
  // next state: occupancy, FSM and watchdog; an abort flushes everything
  always_comb begin
    cnt_d = abort ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    st_d  = abort          ? IDLE :
            st_q == IDLE   ? (cnt_q != 0 ? REQ : IDLE) :
            tmo            ? GAP :
            st_q == GAP    ? (cnt_q != 0 ? REQ : IDLE) :
            done           ? (cnt_d != 0 ? REQ : IDLE) : REQ;
    wd_d  = (TIMEOUT == 0 || st_q != REQ || pop || abort) ? '0 : wd_q + WW'(1);
  end
  // request storage, written on accept
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {s_we, s_adr, s_dat_i, s_sel};
  end
  // control state and registered upstream responses
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_dat_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      wr_q    <= abort ? '0 : push ? wr_q + AW'(1) : wr_q;
      rd_q    <= abort ? '0 : pop ? rd_q + AW'(1) : rd_q;
      s_ack_q <= done & !m_err;
      s_err_q <= (done & m_err) | tmo;
      s_dat_q <= (done & !m_err & !m_we) ? m_dat_i : s_dat_q;
    end
  end
endmodule
